fetch_decode_queue: RTL and testbench
=====================================

// Module: fetch_decode_queue
// PURPOSE
//  Instruction prefetch queue between the fetch stage and the decode stage.
//  - Buffers up to DEPTH {pc, instruction} pairs from fetch (pc = address of the next instruction, i.e. fetch PC + 4).
//  - Lets fetch run ahead while decode is frozen.
//  - Discards all buffered entries when a branch is taken.
//  - Valid/ready handshake on both sides; in-order delivery.
// PARAMETERS
//  DEPTH   4   number of entries; power of two, >= 2
//  AW      2   pointer width; must equal log2(DEPTH)
// PORTS
//  clk              in   1   rising-edge clock
//  rst              in   1   asynchronous reset, active-low (0 = reset)
//  flush            in   1   branch taken; discard all entries
//  in_valid         in   1   fetch presents an entry
//  in_pc            in   32  PC+4 of the fetched instruction
//  in_instruction   in   32  fetched instruction word
//  in_ready         out  1   queue can accept an entry this cycle
//  out_valid        out  1   head entry available to decode
//  out_pc           out  32  head PC+4
//  out_instruction  out  32  head instruction
//  out_ready        in   1   decode consumes head (decode not frozen)
//  count            out  AW+1 current occupancy, 0..DEPTH
// BEHAVIOUR
//  - Reset (rst=0, async): wr_ptr=rd_ptr=0, count=0, storage contents don't-care.
//    Outputs: out_valid=0, in_ready=1, out_pc=0, out_instruction=0. Takes effect immediately, including mid-burst.
//  - push = in_valid & in_ready; pop = out_valid & out_ready; both evaluated at the rising edge.
//  - in_ready = (count != DEPTH). Depends only on registered state, never on out_ready.
//    Consequence: when full, a same-cycle pop does not allow a push.
//  - out_valid = (count != 0). out_pc/out_instruction = entry[rd_ptr] when valid, else 32'd0 (masked).
//  - push: entry[wr_ptr] <= {in_pc, in_instruction}; wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
//  - pop:  rd_ptr <= rd_ptr+1, wrapping modulo DEPTH.
//  - count: +1 on push only; -1 on pop only; unchanged on both or neither.
//  - Latency (bypass off): an entry pushed at edge N is visible on out_* right after edge N. First pop is possible at edge N+1.
//  - flush=1 at an edge: wr_ptr=rd_ptr=count=0; the same-cycle push and pop are both ignored.
//    Next cycle: out_valid=0, in_ready=1. flush takes priority over everything except reset.
//  - flush held high for several cycles: queue stays empty and accepts nothing.
//  - Empty + out_ready=1: no pop, pointers unchanged, no underflow.
//  - Full + in_valid=1: no push, fetch must hold its entry (fetch freeze = ~in_ready).
//  - in_valid/in_pc/in_instruction may change while in_ready=0. The queue samples them only when a push occurs.
// CONFIGURATION
//  FETCH_QUEUE_BYPASS_EN
//   - defined: when count==0 and flush==0, out_valid = in_valid and out_* = in_* combinationally.
//     If out_ready=1 in that cycle, the entry passes straight through: no write, pointers and count unchanged.
//     If out_ready=0, the entry is written normally.
//     Zero-cycle latency through an empty queue.
//   - undefined: no combinational path from in_* to out_*; all rules above apply unchanged.
// TESTING
//  1 reset: rst=0 mid-stream with count=3 -> same cycle out_valid=0, in_ready=1, count=0, out_pc=0.
//  2 fill: out_ready=0, push pc 4,8,12,16 -> count=4, in_ready=0; 5th in_valid ignored.
//    Then out_ready=1 -> pops 4,8,12,16 in order; count reaches 0; out_valid=0.
//  3 full + simultaneous: count=4, in_valid=1, out_ready=1 -> pop only, count=3.
//    Next cycle push+pop -> count stays 3.
//  4 wrap: 10 entries streamed (pc 4..40) with out_ready toggling 1,0,1,...
//    -> all 10 received in order; pointers wrap twice; no loss, no duplication.
//  5 flush: count=3, flush=1 with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0.
//    Next pushed pc 0x100 is the first popped.
//  6 bypass (FETCH_QUEUE_BYPASS_EN): empty, in_valid=1, in_pc=0x20, out_ready=1
//    -> same cycle out_valid=1, out_pc=0x20; after the edge count=0.
//    Without the macro: out_valid=0 that cycle, count=1 after the edge.

Source files
------------

// File: rtl/fetch_decode_queue.sv
// Prefetch queue between fetch and decode: in-order {pc, instruction} FIFO with flush on taken branch.
// Optional zero-latency pass-through through an empty queue when FETCH_QUEUE_BYPASS_EN is defined.
module fetch_decode_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [31:0]   in_pc,
    input  logic [31:0]   in_instruction,
    output logic          in_ready,
    output logic          out_valid,
    output logic [31:0]   out_pc,
    output logic [31:0]   out_instruction,
    input  logic          out_ready,
    output logic [AW:0]   count
);

    // Handshake: a transfer happens on a side only at a rising edge where valid and ready are both high.
    localparam logic [AW:0]   FULL_COUNT = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE    = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE    = {{(AW-1){1'b0}}, 1'b1};

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_q;
    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];

    logic empty;
    logic full;
    logic bypass_sel;
    logic pass_through;
    logic push;
    logic pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_COUNT);

`ifdef FETCH_QUEUE_BYPASS_EN
    // Reset gates the bypass so outputs read zero while rst is low.
    assign bypass_sel = empty & ~flush & rst;
`else
    assign bypass_sel = 1'b0;
`endif

    // An entry consumed straight from the inputs is never written.
    assign pass_through = bypass_sel & in_valid & out_ready;

    assign in_ready = ~full;
    assign push     = in_valid & ~full & ~pass_through & ~flush;
    assign pop      = ~empty & out_ready & ~flush;
    assign count    = count_q;

    always_comb begin
        out_valid       = ~empty;
        out_pc          = 32'd0;
        out_instruction = 32'd0;
        if (bypass_sel) begin
            out_valid       = in_valid;
            out_pc          = in_pc;
            out_instruction = in_instruction;
        end else if (!empty) begin
            out_pc          = pc_mem[rd_ptr];
            out_instruction = instr_mem[rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)      count_q <= count_q + CNT_ONE;
            else if (pop && !push) count_q <= count_q - CNT_ONE;
        end
    end

    // Storage contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= in_pc;
            instr_mem[wr_ptr] <= in_instruction;
        end
    end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Bench for fetch_decode_queue: directed scenarios plus random traffic against a queue-based model.
// Build with +define+FETCH_QUEUE_BYPASS_EN to exercise the pass-through configuration.
module tb_fetch_decode_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [31:0]   in_pc = '0;
    logic [31:0]   in_instruction = '0;
    logic          in_ready;
    logic          out_valid;
    logic [31:0]   out_pc;
    logic [31:0]   out_instruction;
    logic          out_ready = 1'b0;
    logic [AW:0]   count;

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q[$];

    fetch_decode_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_instruction(in_instruction), .in_ready(in_ready),
        .out_valid(out_valid), .out_pc(out_pc), .out_instruction(out_instruction), .out_ready(out_ready),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit model_bypass();
`ifdef FETCH_QUEUE_BYPASS_EN
        return (exp_q.size() == 0) && !flush && rst;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_outputs(input string tag);
        bit          byp;
        logic        ev;
        logic [63:0] ent;
        byp = model_bypass();
        ent = (exp_q.size() != 0) ? exp_q[0] : 64'd0;
        ev  = byp ? in_valid : (exp_q.size() != 0);
        if (byp) ent = {in_pc, in_instruction};
        check_eq({tag, "_count"}, 64'(count), 64'(exp_q.size()));
        check_eq({tag, "_in_ready"}, 64'(in_ready), 64'(exp_q.size() < DEPTH));
        check_eq({tag, "_out_valid"}, 64'(out_valid), 64'(ev));
        check_eq({tag, "_out_entry"}, {out_pc, out_instruction}, ent);
    endtask

    // One cycle, starting and ending at a falling edge.
    task automatic step(input string tag, input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                        input logic ordy, input logic fl, output bit delivered, output logic [31:0] dpc,
                        output bit accepted);
        int sz;
        bit byp, do_pop, do_push;
        in_valid = iv; in_pc = pc; in_instruction = ins; out_ready = ordy; flush = fl;
        #1;
        check_outputs(tag);
        sz      = exp_q.size();
        byp     = model_bypass();
        do_pop  = !fl && sz > 0 && ordy;
        do_push = !fl && iv && sz < DEPTH && !(byp && ordy);
        delivered = out_valid && ordy && !fl;
        dpc       = out_pc;
        accepted  = do_push || (!fl && byp && iv && ordy);
        @(posedge clk);
        if (fl) exp_q.delete();
        else begin
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) exp_q.push_back({pc, ins});
        end
        @(negedge clk);
    endtask

    task automatic step_s(input string tag, input logic iv, input logic [31:0] pc, input logic ordy, input logic fl);
        bit d, a;
        logic [31:0] p;
        step(tag, iv, pc, ~pc, ordy, fl, d, p, a);
    endtask

    task automatic drain();
        for (int i = 0; i < 8; i++) step_s("drain", 1'b0, 32'd0, 1'b1, 1'b0);
    endtask

    initial begin
        bit d, a;
        logic [31:0] p;
        int sent, got;

        // Reset state, outputs held low with stimulus present.
        in_valid = 1'b1; in_pc = 32'h44; out_ready = 1'b1;
        #2;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_count", 64'(count), 64'd0);
        check_eq("rst_out_pc", 64'(out_pc), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Fill to full, fifth entry refused, then drain in order.
        for (int i = 1; i <= 5; i++) step_s("fill", 1'b1, 32'(4 * i), 1'b0, 1'b0);
        check_eq("fill_count", 64'(count), 64'd4);
        check_eq("fill_in_ready", 64'(in_ready), 64'd0);
        for (int i = 1; i <= 4; i++) begin
            step("fill_pop", 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, d, p, a);
            check_eq("fill_order", 64'(p), 64'(4 * i));
        end
        check_eq("fill_empty", 64'(out_valid), 64'd0);

        // Full with simultaneous push/pop: pop only, then steady push+pop.
        for (int i = 1; i <= 4; i++) step_s("full", 1'b1, 32'(16 * i), 1'b0, 1'b0);
        step_s("full_pp", 1'b1, 32'h50, 1'b1, 1'b0);
        check_eq("full_pop_only", 64'(count), 64'd3);
        step_s("full_pp2", 1'b1, 32'h50, 1'b1, 1'b0);
        check_eq("full_steady", 64'(count), 64'd3);
        drain();

        // Wrap: ten entries with out_ready toggling.
        sent = 0; got = 0;
        for (int c = 0; c < 60 && got < 10; c++) begin
            step("wrap", sent < 10, 32'(4 * (sent + 1)), 32'(sent), (c % 2) == 0, 1'b0, d, p, a);
            if (d) begin
                check_eq("wrap_order", 64'(p), 64'(4 * (got + 1)));
                got++;
            end
            if (a) sent++;
        end
        check_eq("wrap_total", 64'(got), 64'd10);

        // Flush with concurrent push and pop.
        for (int i = 1; i <= 3; i++) step_s("pre_flush", 1'b1, 32'(i), 1'b0, 1'b0);
        step_s("flush", 1'b1, 32'h99, 1'b1, 1'b1);
        check_eq("flush_count", 64'(count), 64'd0);
        check_eq("flush_out_valid", 64'(out_valid), 64'd0);
        step_s("post_flush", 1'b1, 32'h100, 1'b0, 1'b0);
        check_eq("flush_first_pc", 64'(out_pc), 64'h100);
        step_s("flush_hold1", 1'b1, 32'h104, 1'b1, 1'b1);
        step_s("flush_hold2", 1'b1, 32'h108, 1'b1, 1'b1);
        check_eq("flush_hold_count", 64'(count), 64'd0);

        // Empty queue, entry offered with decode ready.
        in_valid = 1'b1; in_pc = 32'h20; out_ready = 1'b1; flush = 1'b0;
        #1;
`ifdef FETCH_QUEUE_BYPASS_EN
        check_eq("byp_valid", 64'(out_valid), 64'd1);
        check_eq("byp_pc", 64'(out_pc), 64'h20);
`else
        check_eq("byp_valid", 64'(out_valid), 64'd0);
        check_eq("byp_pc", 64'(out_pc), 64'd0);
`endif
        step_s("byp", 1'b1, 32'h20, 1'b1, 1'b0);
        in_valid = 1'b0;
        #1;
`ifdef FETCH_QUEUE_BYPASS_EN
        check_eq("byp_count", 64'(count), 64'd0);
`else
        check_eq("byp_count", 64'(count), 64'd1);
`endif
        drain();

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            step("rand", $urandom_range(0, 9) < 7, {$urandom_range(0, 32'h3fff_ffff), 2'b00}, $urandom,
                 $urandom_range(0, 1), $urandom_range(0, 15) == 0, d, p, a);
        end

        // Asynchronous reset mid-stream with three entries held.
        drain();
        for (int i = 1; i <= 3; i++) step_s("pre_rst", 1'b1, 32'(8 * i), 1'b0, 1'b0);
        check_eq("pre_rst_count", 64'(count), 64'd3);
        in_valid = 1'b1; out_ready = 1'b1; in_pc = 32'h300;
        #2;
        rst = 1'b0;
        #1;
        exp_q.delete();
        check_eq("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("mid_rst_count", 64'(count), 64'd0);
        check_eq("mid_rst_out_pc", 64'(out_pc), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        step_s("post_rst", 1'b1, 32'h400, 1'b0, 1'b0);
        check_eq("post_rst_pc", 64'(out_pc), 64'h400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
